// File: rtl/parking_slot_controller.sv
// parking_slot_controller
//
// Sequential front end of the parking system. Each raw sensor is passed
// through a two-flop synchroniser and a debounce counter. A rising edge on
// the debounced level becomes a single one-cycle event. The events drive a
// two-state FSM that maintains the 4-slot occupancy map: entries fill the
// lowest free slot, and exits free the slot chosen on i_switch.
//
// Ports:
//   i_clk             system clock (40 MHz domain)
//   i_reset           asynchronous reset, active-low (0 = reset)
//   i_entry_sensor    raw entry sensor, asynchronous, may bounce
//   i_exit_sensor     raw exit sensor, asynchronous, may bounce
//   i_switch[1:0]     index of the slot being vacated, sampled on the exit event
//   o_slots[3:0]      occupancy map, bit i = 1 means slot i is occupied
//   o_door_open_pulse one-cycle pulse on an accepted entry or exit
//   o_full_pulse      one-cycle pulse when an entry is refused because all slots are full
//   o_error_pulse     one-cycle pulse on an exit naming an empty slot, or on a dropped simultaneous entry
//   o_busy            high while the FSM is in HOLD
module parking_slot_controller #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_entry_sensor,
  input  logic       i_exit_sensor,
  input  logic [1:0] i_switch,
  output logic [3:0] o_slots,
  output logic       o_door_open_pulse,
  output logic       o_full_pulse,
  output logic       o_error_pulse,
  output logic       o_busy
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  // Index 0 is the entry sensor and index 1 is the exit sensor.
  logic [1:0]            w_raw;
  logic [1:0]            r_sync1;
  logic [1:0]            r_sync2;
  logic [1:0]            r_level;
  logic [1:0]            r_prev;
  logic [1:0][CNT_W-1:0] r_cnt;

  logic       w_entryRise;
  logic       w_exitRise;
  logic [3:0] w_fillMask;
  logic       w_full;

  logic [0:0] r_state;
  logic [3:0] r_slots;
  logic       r_door;
  logic       r_fullPulse;
  logic       r_error;

  assign w_raw = {i_exit_sensor, i_entry_sensor};

  // Synchroniser, debounce counter and previous-level register for both sensors.
  // The counter reaches its terminal value on the DEBOUNCE_CYCLES-th consecutive
  // differing sample. At that point the debounced level adopts the new value.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_level <= '0;
      r_prev  <= '0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      r_prev  <= r_level;
      for (int s = 0; s < 2; s++) begin
        if (r_sync2[s] == r_level[s]) begin
          r_cnt[s] <= '0;
        end else if (r_cnt[s] == CNT_LAST) begin
          r_level[s] <= r_sync2[s];
          r_cnt[s]   <= '0;
        end else begin
          r_cnt[s] <= r_cnt[s] + 1'b1;
        end
      end
    end
  end

  assign w_entryRise = r_level[0] & ~r_prev[0];
  assign w_exitRise  = r_level[1] & ~r_prev[1];

  // ~s & (s + 1) isolates the lowest zero bit of s.
  // When all four slots are occupied, the sum wraps to zero, so the mask is empty.
  assign w_fillMask = ~r_slots & (r_slots + 4'd1);
  assign w_full     = &r_slots;

  // Event FSM. All pulses default low, so each pulse lasts exactly one cycle.
  // An exit takes precedence over a simultaneous entry. The dropped entry is
  // reported on the error pulse.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state     <= ST_IDLE;
      r_slots     <= '0;
      r_door      <= 1'b0;
      r_fullPulse <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_door      <= 1'b0;
      r_fullPulse <= 1'b0;
      r_error     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_exitRise) begin
            r_state <= ST_HOLD;
            if (r_slots[i_switch]) begin
              r_slots[i_switch] <= 1'b0;
              r_door            <= 1'b1;
            end else begin
              r_error <= 1'b1;
            end
            if (w_entryRise) begin
              r_error <= 1'b1;
            end
          end else if (w_entryRise) begin
            r_state <= ST_HOLD;
            if (w_full) begin
              r_fullPulse <= 1'b1;
            end else begin
              r_slots <= r_slots | w_fillMask;
              r_door  <= 1'b1;
            end
          end
        end
        default: begin
          if (r_level == 2'b00) begin
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign o_slots           = r_slots;
  assign o_door_open_pulse = r_door;
  assign o_full_pulse      = r_fullPulse;
  assign o_error_pulse     = r_error;
  assign o_busy            = (r_state == ST_HOLD);

endmodule

// File: tb/tb_parking_slot_controller.sv
// tb_parking_slot_controller
//
// Testbench for parking_slot_controller with DEBOUNCE_CYCLES = 4.
// The stimulus process updates an abstract model of the car park (an occupancy
// vector and its lowest-free rule). For every press it queues the expected
// pulse set, the resulting slot map and the clock cycle at which the pulse
// should appear. A separate monitor pops one entry each time the DUT raises
// any pulse, and between pulses it checks that the slot map stays put.
module tb_parking_slot_controller;

  localparam int N = 4;

  logic       clk;
  logic       rst_n;
  logic       entrySensor;
  logic       exitSensor;
  logic [1:0] switchIn;
  logic [3:0] slots;
  logic       door;
  logic       full;
  logic       err;
  logic       busy;

  typedef struct {
    logic [3:0] slots;
    logic       door;
    logic       full;
    logic       err;
    int         cyc;
  } exp_t;

  exp_t       expQ[$];
  exp_t       monItem;
  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;
  logic [3:0] modelSlots = 4'b0000;
  logic [3:0] monSlots = 4'b0000;

  parking_slot_controller #(.DEBOUNCE_CYCLES(N)) dut (
    .i_clk            (clk),
    .i_reset          (rst_n),
    .i_entry_sensor   (entrySensor),
    .i_exit_sensor    (exitSensor),
    .i_switch         (switchIn),
    .o_slots          (slots),
    .o_door_open_pulse(door),
    .o_full_pulse     (full),
    .o_error_pulse    (err),
    .o_busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Monitor: each pulse cycle consumes one scoreboard entry.
  // In every other cycle, the slot map must match the last confirmed map.
  always @(negedge clk) begin
    if (rst_n) begin
      if (door || full || err) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_pulse", {29'd0, door, full, err}, 32'd0);
        end else begin
          monItem = expQ.pop_front();
          checkOutput("slots", {28'd0, slots}, {28'd0, monItem.slots});
          checkOutput("door_pulse", {31'd0, door}, {31'd0, monItem.door});
          checkOutput("full_pulse", {31'd0, full}, {31'd0, monItem.full});
          checkOutput("error_pulse", {31'd0, err}, {31'd0, monItem.err});
          checkOutput("pulse_cycle", cyc, monItem.cyc);
          monSlots = monItem.slots;
        end
      end else begin
        checkOutput("slots_stable", {28'd0, slots}, {28'd0, monSlots});
      end
    end
  end

  // One press of entry and/or exit. The expectation is derived from the park
  // rules: an exit wins and frees slot sw if it is occupied; an entry takes the
  // lowest empty slot or reports full. When repress is set, the entry sensor is
  // released and pressed again while the exit sensor keeps the FSM in HOLD.
  task automatic applyStimulus(input bit doEntry, input bit doExit, input logic [1:0] sw,
                               input int holdCycles, input bit repress);
    exp_t x;
    int   freeIdx;
    @(negedge clk);
    x.slots = modelSlots;
    x.door  = 1'b0;
    x.full  = 1'b0;
    x.err   = 1'b0;
    if (doExit) begin
      if (modelSlots[sw]) begin
        x.slots[sw] = 1'b0;
        x.door      = 1'b1;
      end else begin
        x.err = 1'b1;
      end
      if (doEntry) x.err = 1'b1;
    end else if (doEntry) begin
      freeIdx = -1;
      for (int i = 3; i >= 0; i--) if (!modelSlots[i]) freeIdx = i;
      if (freeIdx < 0) begin
        x.full = 1'b1;
      end else begin
        x.slots[freeIdx] = 1'b1;
        x.door           = 1'b1;
      end
    end
    x.cyc      = cyc + N + 3;
    modelSlots = x.slots;
    expQ.push_back(x);
    switchIn    = sw;
    entrySensor = doEntry;
    exitSensor  = doExit;
    repeat (N + 4) @(negedge clk);
    checkOutput("busy_during_hold", {31'd0, busy}, 32'd1);
    repeat (holdCycles) @(negedge clk);
    if (repress) begin
      entrySensor = 1'b0;
      repeat (N + 3) @(negedge clk);
      entrySensor = 1'b1;
      repeat (N + 4) @(negedge clk);
      checkOutput("busy_still_hold", {31'd0, busy}, 32'd1);
    end
    entrySensor = 1'b0;
    exitSensor  = 1'b0;
    repeat (N + 6) @(negedge clk);
    checkOutput("busy_after_release", {31'd0, busy}, 32'd0);
  endtask

  // A bounce shorter than the debounce window; no event is queued for it.
  task automatic glitch(input bit onExit, input int len);
    @(negedge clk);
    if (onExit) exitSensor = 1'b1; else entrySensor = 1'b1;
    repeat (len) @(negedge clk);
    entrySensor = 1'b0;
    exitSensor  = 1'b0;
    repeat (N + 6) @(negedge clk);
  endtask

  // Asserts reset partway through an entry debounce and expects all outputs to
  // clear at once. The park is then empty.
  task automatic resetMidDebounce();
    @(negedge clk);
    entrySensor = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_slots", {28'd0, slots}, 32'd0);
    checkOutput("rst_door", {31'd0, door}, 32'd0);
    checkOutput("rst_full", {31'd0, full}, 32'd0);
    checkOutput("rst_error", {31'd0, err}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    expQ.delete();
    modelSlots  = 4'b0000;
    monSlots    = 4'b0000;
    entrySensor = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (N + 8) @(negedge clk);
  endtask

  initial begin
    int r;
    rst_n       = 1'b0;
    entrySensor = 1'b0;
    exitSensor  = 1'b0;
    switchIn    = 2'd0;
    repeat (3) @(negedge clk);
    checkOutput("reset_slots", {28'd0, slots}, 32'd0);
    checkOutput("reset_door", {31'd0, door}, 32'd0);
    checkOutput("reset_full", {31'd0, full}, 32'd0);
    checkOutput("reset_error", {31'd0, err}, 32'd0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Fill all four slots, then refuse a fifth car.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 2'd0, 2, 1'b0);
    // Free slot 3 and then slot 1; the next entry refills slot 1.
    applyStimulus(1'b0, 1'b1, 2'd3, 1, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'd1, 1, 1'b0);
    applyStimulus(1'b1, 1'b0, 2'd0, 1, 1'b0);
    // Leave only slot 0 occupied, then exit from empty slot 3.
    applyStimulus(1'b0, 1'b1, 2'd1, 0, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'd2, 0, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'd3, 0, 1'b0);
    glitch(1'b0, 3);
    glitch(1'b1, 3);
    // Refill to 1111, then press entry and exit together with switch 2,
    // plus a second entry press while in HOLD.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 2'd0, 0, 1'b0);
    applyStimulus(1'b1, 1'b1, 2'd2, 0, 1'b1);
    // Bring the map to 0011, then reset partway through an entry debounce.
    applyStimulus(1'b0, 1'b1, 2'd3, 0, 1'b0);
    resetMidDebounce();
    applyStimulus(1'b1, 1'b0, 2'd0, 0, 1'b0);

    for (int k = 0; k < 30; k++) begin
      r = $urandom_range(0, 9);
      if (r <= 3)      applyStimulus(1'b1, 1'b0, 2'($urandom_range(0, 3)), $urandom_range(0, 3), 1'b0);
      else if (r <= 6) applyStimulus(1'b0, 1'b1, 2'($urandom_range(0, 3)), $urandom_range(0, 3), 1'b0);
      else if (r == 7) applyStimulus(1'b1, 1'b1, 2'($urandom_range(0, 3)), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      else             glitch(1'($urandom_range(0, 1)), $urandom_range(1, N - 1));
    end

    for (int w = 0; w < 50 && expQ.size() > 0; w++) @(negedge clk);
    checkOutput("queue_drained", expQ.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
